fifo_uart_tx: RTL and testbench

Downstream drain stage for sync_fifo. It pops one byte at a time whenever the FIFO is non-empty and serialises it onto a single UART-style TX line: start bit, data LSB first, optional parity, then stop bit(s). It sits between the byte FIFO and the chip pin, and exposes busy and frame-done status for firmware and debug.

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/fifo_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the FIFO-fed UART transmitter:
//               FSM state encoding, line levels and a frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Transmitter FSM states, 3-bit explicit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_tx_state_t;

    // Serial line levels
    localparam logic c_IDLE_LEVEL  = 1'b1;
    localparam logic c_START_LEVEL = 1'b0;

    // Total clk cycles occupied by one frame on the line
    function automatic int unsigned frame_cycles(
        input int unsigned data_width,
        input int unsigned clks_per_bit,
        input int unsigned parity_en,
        input int unsigned stop_bits
    );
        return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//               last cycle of each bit period. Restart clears the count.
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous active-low reset
//               restart  - hold count at 0 (used outside the serial states)
//               bit_end  - high on the last cycle of a bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int                c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bit_end = (r_cnt == c_LAST);

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drains a registered-read byte FIFO and serialises each word
//               as a UART frame: start bit, data LSB first, optional parity,
//               one or two stop bits.
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               fifo_empty - FIFO empty flag
//               fifo_rd_en - one-cycle pop strobe per byte
//               fifo_data  - FIFO read data, valid the cycle after the pop
//               tx         - serial line, idles high
//               busy       - high from fetch until the end of the last stop bit
//               frame_done - one-cycle pulse after the last stop-bit cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    // Index counter must cover both data bits and stop bits
    localparam int                 c_IDX_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA  = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP  = c_IDX_W'(STOP_BITS - 1);
    localparam logic               c_PARITY_INV = (PARITY_ODD != 0);

    uart_tx_state_t        r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_bit_end;
    logic                  w_timer_restart;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // The timer only runs while a bit is on the line. Every transition
    // between serial states happens on a bit boundary, where the counter
    // wraps to 0, so each state is entered with a fresh count.
    assign w_timer_restart = (r_state == ST_IDLE) || (r_state == ST_FETCH) ||
                             (r_state == ST_LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_timer_restart),
        .bit_end (w_bit_end)
    );

    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
            r_tx      <= c_IDLE_LEVEL;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= c_IDLE_LEVEL;
                    if (!fifo_empty) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end

                // Read data from the FIFO is valid now, one cycle after the pop
                ST_LOAD: begin
                    r_shift   <= fifo_data;
                    r_parity  <= (^fifo_data) ^ c_PARITY_INV;
                    r_bit_idx <= '0;
                    r_tx      <= c_START_LEVEL;
                    r_state   <= ST_START;
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_next;
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= c_IDLE_LEVEL;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                            r_tx      <= w_shift_next[0];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= c_IDLE_LEVEL;
                        r_state   <= ST_STOP;
                    end
                end

                // Last stop cycle is the only other place fifo_empty is
                // sampled; a waiting byte is fetched with no idle gap.
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_done    <= 1'b1;
                            if (!fifo_empty) begin
                                r_state <= ST_FETCH;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= c_IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = (r_state == ST_FETCH);
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Directed self-checking bench for fifo_uart_tx. Four DUT
//               instances cover the parameter sets of interest:
//                 0: CLKS_PER_BIT=4, no parity, 1 stop
//                 1: CLKS_PER_BIT=4, even parity, 1 stop
//                 2: CLKS_PER_BIT=4, odd parity, 1 stop
//                 3: CLKS_PER_BIT=2, no parity, 2 stops
//               Each instance is fed by a small registered-read FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] fifo_empty;
    logic [3:0] fifo_rd_en;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] frame_done;
    logic [7:0] fdata [4] = '{default: 8'h00};

    // FIFO models: bench writes mem/wr, the pop process owns rd/fdata
    logic [7:0] mem [4][16];
    int         wr [4] = '{default: 0};
    int         rd [4] = '{default: 0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (wr[i] == rd[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en[i]) begin
                fdata[i] <= mem[i][rd[i] % 16];
                rd[i]    <= rd[i] + 1;
            end
        end
    end

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
        .fifo_data(fdata[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
        .fifo_data(fdata[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[2]), .fifo_rd_en(fifo_rd_en[2]),
        .fifo_data(fdata[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[3]), .fifo_rd_en(fifo_rd_en[3]),
        .fifo_data(fdata[3]), .tx(tx[3]), .busy(busy[3]), .frame_done(frame_done[3]));

    // Push a byte into FIFO model i (call just after a negedge)
    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr[i] % 16] = b;
        wr[i] = wr[i] + 1;
    endtask

    // Advance negedges until instance i shows its pop strobe
    task automatic wait_fetch(input int i, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_rd_en[i] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: fifo_rd_en actual 0 for 10 cycles, required 1", name);
        end
    endtask

    // Walk one frame from its FETCH cycle. bits[k] is the required line level
    // of bit period k; 'more' says whether another byte follows back to back.
    task automatic walk_frame(input int i, input int cpb, input int nbits,
                              input logic [15:0] bits, input logic more,
                              input string name);
        logic exp_tx;
        @(negedge clk); // LOAD
        checks++;
        if ({tx[i], busy[i], fifo_rd_en[i], frame_done[i]} !== 4'b1100) begin
            errors++;
            $display("FAIL %s load: tx/busy/rd_en/done actual %b%b%b%b required 1100",
                     name, tx[i], busy[i], fifo_rd_en[i], frame_done[i]);
        end
        for (int k = 0; k < nbits * cpb; k++) begin
            @(negedge clk);
            exp_tx = bits[k / cpb];
            checks++;
            if ({tx[i], busy[i], fifo_rd_en[i], frame_done[i]} !== {exp_tx, 3'b100}) begin
                errors++;
                $display("FAIL %s cycle %0d: tx/busy/rd_en/done actual %b%b%b%b required %b100",
                         name, k, tx[i], busy[i], fifo_rd_en[i], frame_done[i], exp_tx);
            end
        end
        @(negedge clk); // cycle after the last stop cycle
        checks++;
        if ({frame_done[i], busy[i], fifo_rd_en[i], tx[i]} !== {1'b1, more, more, 1'b1}) begin
            errors++;
            $display("FAIL %s end: done/busy/rd_en/tx actual %b%b%b%b required 1%b%b1",
                     name, frame_done[i], busy[i], fifo_rd_en[i], tx[i], more, more);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 4'hF) begin
            errors++;
            $display("FAIL reset_tx: actual %b required 1111", tx);
        end
        checks++;
        if (busy !== 4'h0) begin
            errors++;
            $display("FAIL reset_busy: actual %b required 0000", busy);
        end
        checks++;
        if (fifo_rd_en !== 4'h0) begin
            errors++;
            $display("FAIL reset_rd_en: actual %b required 0000", fifo_rd_en);
        end
        checks++;
        if (frame_done !== 4'h0) begin
            errors++;
            $display("FAIL reset_done: actual %b required 0000", frame_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_empty_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({fifo_rd_en, tx, busy} !== {4'h0, 4'hF, 4'h0}) begin
                errors++;
                $display("FAIL empty_idle cycle %0d: rd_en/tx/busy actual %b/%b/%b required 0000/1111/0000",
                         k, fifo_rd_en, tx, busy);
            end
        end
    endtask

    task automatic test_single_frame();
        push(0, 8'hA5);
        wait_fetch(0, "single_a5_fetch");
        // start, A5 LSB first = 1,0,1,0,0,1,0,1, stop
        walk_frame(0, 4, 10, 16'b000000_1_10100101_0, 1'b0, "single_a5");
        @(negedge clk);
        checks++;
        if ({frame_done[0], busy[0], fifo_rd_en[0]} !== 3'b000) begin
            errors++;
            $display("FAIL single_a5_after: done/busy/rd_en actual %b%b%b required 000",
                     frame_done[0], busy[0], fifo_rd_en[0]);
        end
    endtask

    task automatic test_parity();
        // A5 has four ones: even parity bit 0, odd parity bit 1; 44 cycles
        push(1, 8'hA5);
        wait_fetch(1, "parity_even_fetch");
        walk_frame(1, 4, 11, 16'b00000_1_0_10100101_0, 1'b0, "parity_even");
        push(2, 8'hA5);
        wait_fetch(2, "parity_odd_fetch");
        walk_frame(2, 4, 11, 16'b00000_1_1_10100101_0, 1'b0, "parity_odd");
    endtask

    task automatic test_back_to_back();
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        wait_fetch(0, "b2b_fetch");
        walk_frame(0, 4, 10, 16'b000000_1_00000001_0, 1'b1, "b2b_01");
        walk_frame(0, 4, 10, 16'b000000_1_00000010_0, 1'b1, "b2b_02");
        walk_frame(0, 4, 10, 16'b000000_1_00000011_0, 1'b0, "b2b_03");
    endtask

    task automatic test_two_stop();
        // 9 low bits * 2 = 18 low cycles, then 2 stops * 2 = 4 high cycles
        push(3, 8'h00);
        push(3, 8'h00);
        wait_fetch(3, "stop2_fetch");
        walk_frame(3, 2, 11, 16'b00000_11_00000000_0, 1'b1, "stop2_first");
        walk_frame(3, 2, 11, 16'b00000_11_00000000_0, 1'b0, "stop2_second");
    endtask

    task automatic test_reset_mid_frame();
        push(0, 8'hFF);
        push(0, 8'h3C);
        wait_fetch(0, "midrst_fetch");
        // LOAD, START (4), data bits 0..2 (12), then first cycle of bit 3
        repeat (1 + 4 + 12 + 1) @(negedge clk);
        checks++;
        if ({tx[0], busy[0]} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_inflight: tx/busy actual %b%b required 11", tx[0], busy[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx[0], busy[0], fifo_rd_en[0], frame_done[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_reset: tx/busy/rd_en/done actual %b%b%b%b required 1000",
                     tx[0], busy[0], fifo_rd_en[0], frame_done[0]);
        end
        rst_n = 1'b1;
        wait_fetch(0, "midrst_next_fetch");
        // Next frame carries 0x3C: LSB first 0,0,1,1,1,1,0,0
        walk_frame(0, 4, 10, 16'b000000_1_00111100_0, 1'b0, "midrst_next");
    endtask

    initial begin
        test_reset();
        test_empty_idle();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire
